// File: rtl/comm_master_q.sv
// comm_master_q: command queue feeding a UART 8N1 frame transmitter, with an always-on response receiver.
// Optional response timeout is built only when COMM_TIMEOUT_EN is defined.
module comm_master_q #(
  parameter int DATA_W    = 16,
  parameter int CMD_DEPTH = 4,
  parameter int BAUD_DIV  = 2604,
  parameter int RESP_TMO  = 2000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        cmd,
  input  logic [DATA_W-1:0] data,
  input  logic              snd_cmd,
  output logic              cmd_full,
  output logic              TX,
  input  logic              RX,
  output logic              frm_snt,
  output logic [7:0]        resp,
  output logic              resp_rdy,
  input  logic              clr_resp_rdy,
  output logic              busy,
  output logic              tmo,
  output logic              drop
);

  localparam int FW   = DATA_W + 8;
  localparam int NB   = FW / 8;
  localparam int AW   = $clog2(CMD_DEPTH);
  localparam int BW   = $clog2(BAUD_DIV + 1);
  localparam int YW   = $clog2(NB + 1);
  localparam int HALF = BAUD_DIV / 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    SEND      = 2'd2,
    WAIT_RESP = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [FW-1:0]     q_mem [CMD_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count, count_nxt;
  logic              push_ok, pop;
  logic [FW-1:0]     shreg;
  logic [BW-1:0]     baud_cnt;
  logic [3:0]        bit_cnt;
  logic [YW-1:0]     byte_cnt;
  logic [7:0]        byte_cur;
  logic              bit_end, last_bit;
  logic              rx_meta, rx_sync, rx_prev, rx_active, rx_sample, rx_done;
  logic [BW-1:0]     rx_cnt;
  logic [3:0]        rx_bit;
  logic [7:0]        rx_shift;
  logic              tmo_hit;

  assign push_ok  = snd_cmd & ~cmd_full;
  assign byte_cur = shreg[FW-1 -: 8];
  assign bit_end  = (baud_cnt == BW'(BAUD_DIV - 1));
  assign last_bit = bit_end && (bit_cnt == 4'd9) && (byte_cnt == YW'(NB - 1));

  always_ff @(posedge clk) begin
    if (push_ok) q_mem[wr_ptr] <= {cmd, data};
  end

  always_comb begin
    count_nxt = count;
    if (push_ok && !pop) count_nxt = count + (AW+1)'(1);
    else if (!push_ok && pop) count_nxt = count - (AW+1)'(1);
    else count_nxt = count;
  end

  // Refused pushes never reach memory; drop remembers them until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= AW'(0);
      rd_ptr   <= AW'(0);
      count    <= (AW+1)'(0);
      cmd_full <= 1'b0;
      drop     <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count    <= count_nxt;
      cmd_full <= (count_nxt == (AW+1)'(CMD_DEPTH));
      if (snd_cmd && cmd_full) drop <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (count != (AW+1)'(0)) state_nxt = LOAD;
        else state_nxt = IDLE;
      end
      LOAD: begin
        pop       = 1'b1;
        state_nxt = SEND;
      end
      SEND: begin
        if (last_bit) state_nxt = WAIT_RESP;
        else state_nxt = SEND;
      end
      WAIT_RESP: begin
        if (rx_done || tmo_hit) state_nxt = IDLE;
        else state_nxt = WAIT_RESP;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
    end
  end

  // TX holds the level of the bit currently on the line; bit_cnt 0 is start, 9 is stop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      TX       <= 1'b1;
      shreg    <= FW'(0);
      baud_cnt <= BW'(0);
      bit_cnt  <= 4'd0;
      byte_cnt <= YW'(0);
      frm_snt  <= 1'b0;
    end else begin
      frm_snt <= 1'b0;
      case (state)
        LOAD: begin
          shreg    <= q_mem[rd_ptr];
          TX       <= 1'b0;
          baud_cnt <= BW'(0);
          bit_cnt  <= 4'd0;
          byte_cnt <= YW'(0);
        end
        SEND: begin
          if (!bit_end) begin
            baud_cnt <= baud_cnt + BW'(1);
          end else if (bit_cnt != 4'd9) begin
            baud_cnt <= BW'(0);
            bit_cnt  <= bit_cnt + 4'd1;
            TX       <= (bit_cnt == 4'd8) ? 1'b1 : byte_cur[bit_cnt[2:0]];
          end else if (last_bit) begin
            baud_cnt <= BW'(0);
            bit_cnt  <= 4'd0;
            byte_cnt <= YW'(0);
            TX       <= 1'b1;
            frm_snt  <= 1'b1;
          end else begin
            baud_cnt <= BW'(0);
            bit_cnt  <= 4'd0;
            byte_cnt <= byte_cnt + YW'(1);
            shreg    <= shreg << 8;
            TX       <= 1'b0;
          end
        end
        default: begin
          TX       <= 1'b1;
          baud_cnt <= BW'(0);
          bit_cnt  <= 4'd0;
          byte_cnt <= YW'(0);
        end
      endcase
    end
  end

  assign rx_sample = rx_active &&
                     (rx_cnt == ((rx_bit == 4'd0) ? BW'(HALF - 1) : BW'(BAUD_DIV - 1)));
  assign rx_done   = rx_sample && (rx_bit == 4'd9) && rx_sync;

  // Start is armed only on a falling edge, so a line held low after a framing error is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta   <= 1'b1;
      rx_sync   <= 1'b1;
      rx_prev   <= 1'b1;
      rx_active <= 1'b0;
      rx_cnt    <= BW'(0);
      rx_bit    <= 4'd0;
      rx_shift  <= 8'h00;
    end else begin
      rx_meta <= RX;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
      if (!rx_active) begin
        rx_cnt <= BW'(0);
        rx_bit <= 4'd0;
        if (rx_prev && !rx_sync) rx_active <= 1'b1;
      end else if (rx_sample) begin
        rx_cnt <= BW'(0);
        case (rx_bit)
          4'd0: begin
            if (rx_sync) rx_active <= 1'b0;
            else rx_bit <= 4'd1;
          end
          4'd9: begin
            rx_active <= 1'b0;
            rx_bit    <= 4'd0;
          end
          default: begin
            rx_shift <= {rx_sync, rx_shift[7:1]};
            rx_bit   <= rx_bit + 4'd1;
          end
        endcase
      end else begin
        rx_cnt <= rx_cnt + BW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp     <= 8'h00;
      resp_rdy <= 1'b0;
    end else begin
      if (rx_done) resp <= rx_shift;
      if (rx_done) resp_rdy <= 1'b1;
      else if (clr_resp_rdy) resp_rdy <= 1'b0;
    end
  end

`ifdef COMM_TIMEOUT_EN
  localparam int TW = $clog2(RESP_TMO + 1);
  logic [TW-1:0] tmo_cnt;

  assign tmo_hit = (state == WAIT_RESP) && (tmo_cnt == TW'(RESP_TMO - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= TW'(0);
      tmo     <= 1'b0;
    end else begin
      tmo <= tmo_hit & ~rx_done;
      if ((state == WAIT_RESP) && !tmo_hit && !rx_done) tmo_cnt <= tmo_cnt + TW'(1);
      else tmo_cnt <= TW'(0);
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign tmo     = 1'b0;
`endif

endmodule

// File: tb/tb_comm_master_q.sv
// Self-checking bench for comm_master_q: random command traffic against a frame-queue model,
// plus directed reset, overflow, framing-error and response-wait cases.
module tb_comm_master_q;
  localparam int DATA_W    = 16;
  localparam int CMD_DEPTH = 4;
  localparam int BAUD_DIV  = 8;
  localparam int RESP_TMO  = 500;
  localparam int BIT_T     = BAUD_DIV * 10;

  logic              clk = 1'b0;
  logic              rst, snd_cmd, RX, clr_resp_rdy;
  logic              cmd_full, TX, frm_snt, resp_rdy, busy, tmo, drop;
  logic [7:0]        cmd, resp;
  logic [DATA_W-1:0] data;

  int          checks = 0, errors = 0;
  int          frm_cnt = 0, frm_exp = 0, tmo_cnt = 0;
  int          cyc = 0, frm_cyc = 0, tmo_cyc = 0;
  int          dec_q[$];
  logic [23:0] exp_q[$];
  logic        drop_exp = 1'b0;
  logic [7:0]  last_resp = 8'h00;

  comm_master_q #(
    .DATA_W(DATA_W), .CMD_DEPTH(CMD_DEPTH), .BAUD_DIV(BAUD_DIV), .RESP_TMO(RESP_TMO)
  ) dut (
    .clk(clk), .rst(rst), .cmd(cmd), .data(data), .snd_cmd(snd_cmd), .cmd_full(cmd_full),
    .TX(TX), .RX(RX), .frm_snt(frm_snt), .resp(resp), .resp_rdy(resp_rdy),
    .clr_resp_rdy(clr_resp_rdy), .busy(busy), .tmo(tmo), .drop(drop)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frm_snt === 1'b1) begin frm_cnt++; frm_cyc = cyc; end
    if (tmo === 1'b1) begin tmo_cnt++; tmo_cyc = cyc; end
  end

  // Line-side UART decoder; a byte with a bad stop bit is tagged with bit 8.
  initial begin
    logic [7:0] b;
    logic       stp;
    forever begin
      @(negedge TX);
      #(BIT_T/2 + 5);
      if (TX == 1'b0) begin
        for (int i = 0; i < 8; i++) begin #(BIT_T); b[i] = TX; end
        #(BIT_T);
        stp = TX;
        dec_q.push_back(stp ? int'(b) : (int'(b) | 256));
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_n(input int n, input logic fixed, input logic [7:0] c, input logic [15:0] d);
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      if (fixed) begin cmd = c; data = d; end
      else begin cmd = 8'($urandom); data = 16'($urandom); end
      snd_cmd = 1'b1;
      if (exp_q.size() < CMD_DEPTH) exp_q.push_back({cmd, data});
      else drop_exp = 1'b1;
      @(negedge clk);
    end
    snd_cmd = 1'b0;
  endtask

  task automatic expect_frame();
    logic [23:0] f;
    int          t, got;
    check("frame_pending", 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) f = exp_q.pop_front();
    else f = 24'h000000;
    t = 0;
    while (dec_q.size() < 3 && t < 3000) begin @(negedge clk); t++; end
    for (int k = 0; k < 3; k++) begin
      if (dec_q.size() > 0) got = dec_q.pop_front();
      else got = -1;
      check($sformatf("tx_byte%0d", k), got, 32'((f >> (16 - 8*k)) & 24'hFF));
    end
    frm_exp++;
    t = 0;
    while (frm_cnt < frm_exp && t < 200) begin @(negedge clk); t++; end
    check("frm_snt_count", frm_cnt, frm_exp);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    @(negedge clk);
    RX = 1'b0;
    #(BIT_T);
    for (int i = 0; i < 8; i++) begin RX = b[i]; #(BIT_T); end
    RX = stop;
    #(BIT_T);
    RX = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic clear_rdy();
    clr_resp_rdy = 1'b1;
    @(negedge clk);
    clr_resp_rdy = 1'b0;
    check("resp_rdy_clr", resp_rdy, 32'd0);
  endtask

  task automatic respond(input logic [7:0] b);
    send_rx(b, 1'b1);
    last_resp = b;
    check("resp", resp, b);
    check("resp_rdy_set", resp_rdy, 32'd1);
    clear_rdy();
  endtask

  initial begin
    int   lat, t, k;
    logic busy_low;
    rst = 1'b1; snd_cmd = 1'b0; cmd = 8'h00; data = 16'h0000; RX = 1'b1; clr_resp_rdy = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", TX, 32'd1);
    check("rst_frm_snt", frm_snt, 32'd0);
    check("rst_resp", resp, 32'h00);
    check("rst_resp_rdy", resp_rdy, 32'd0);
    check("rst_busy", busy, 32'd0);
    check("rst_tmo", tmo, 32'd0);
    check("rst_drop", drop, 32'd0);
    check("rst_cmd_full", cmd_full, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single command 01/0000: latency, busy through the frame, decoded bytes.
    push_n(1, 1'b1, 8'h01, 16'h0000);
    lat = 0;
    while (TX === 1'b1 && lat < 20) begin @(negedge clk); lat++; end
    check("start_latency_le3", 32'(lat <= 3), 32'd1);
    busy_low = 1'b0; t = 0;
    while (frm_cnt == frm_exp && t < 1000) begin
      if (busy !== 1'b1) busy_low = 1'b1;
      @(negedge clk); t++;
    end
    expect_frame();
    check("busy_dropped_in_frame", busy_low, 32'd0);
    check("busy_wait_resp", busy, 32'd1);

    send_rx(8'hC0, 1'b1);
    last_resp = 8'hC0;
    check("resp_c0", resp, 32'hC0);
    check("resp_rdy_c0", resp_rdy, 32'd1);
    check("idle_after_resp", busy, 32'd0);
    clear_rdy();

    // Random rounds: one frame, then 0..4 pushes while waiting for its response.
    for (int r = 0; r < 4; r++) begin
      push_n(1, 1'b0, 8'h00, 16'h0000);
      expect_frame();
      k = $urandom_range(0, 4);
      push_n(k, 1'b0, 8'h00, 16'h0000);
      check("cmd_full_rand", cmd_full, 32'(exp_q.size() == CMD_DEPTH));
      respond(8'($urandom));
      while (exp_q.size() > 0) begin
        expect_frame();
        respond(8'($urandom));
      end
      check("drop_rand", drop, drop_exp);
      check("idle_rand", busy, 32'd0);
    end

    // Overflow: five pushes while waiting, four survive in order.
    push_n(1, 1'b0, 8'h00, 16'h0000);
    expect_frame();
    push_n(5, 1'b0, 8'h00, 16'h0000);
    check("ovf_cmd_full", cmd_full, 32'd1);
    check("ovf_drop", drop, drop_exp);
    respond(8'($urandom));
    while (exp_q.size() > 0) begin
      expect_frame();
      respond(8'($urandom));
    end
    check("ovf_cmd_full_drained", cmd_full, 32'd0);
    check("ovf_drop_sticky", drop, 32'd1);

    // Framing error leaves resp alone; a good byte in IDLE is still captured.
    send_rx(8'h5A, 1'b0);
    repeat (20) @(negedge clk);
    check("bad_stop_rdy", resp_rdy, 32'd0);
    check("bad_stop_resp", resp, last_resp);
    respond(8'hA5);

`ifdef COMM_TIMEOUT_EN
    push_n(1, 1'b0, 8'h00, 16'h0000);
    expect_frame();
    push_n(1, 1'b0, 8'h00, 16'h0000);
    t = 0;
    while (tmo_cnt == 0 && t < 700) begin @(negedge clk); t++; end
    check("tmo_pulses", tmo_cnt, 32'd1);
    check("tmo_delay", tmo_cyc - frm_cyc, 32'd500);
    expect_frame();
    respond(8'($urandom));
`else
    push_n(1, 1'b0, 8'h00, 16'h0000);
    expect_frame();
    repeat (600) @(negedge clk);
    check("no_tmo", tmo_cnt, 32'd0);
    check("wait_forever_busy", busy, 32'd1);
    respond(8'($urandom));
`endif

    // Reset in the middle of the second data byte with another entry queued.
    push_n(1, 1'b0, 8'h00, 16'h0000);
    t = 0;
    while (TX === 1'b1 && t < 20) begin @(negedge clk); t++; end
    push_n(1, 1'b0, 8'h00, 16'h0000);
    repeat (170) @(negedge clk);
    check("pre_rst_tx_busy", busy, 32'd1);
    #3 rst = 1'b1;
    #1;
    check("rst_mid_tx", TX, 32'd1);
    check("rst_mid_busy", busy, 32'd0);
    check("rst_mid_drop", drop, 32'd0);
    check("rst_mid_cmd_full", cmd_full, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    drop_exp = 1'b0;
    last_resp = 8'h00;
    check("rst_mid_resp", resp, 32'h00);
    repeat (300) @(negedge clk);
    check("rst_no_frm_snt", frm_cnt, frm_exp);
    check("rst_queue_empty", busy, 32'd0);
    check("rst_tx_idle", TX, 32'd1);
    dec_q.delete();
    push_n(1, 1'b0, 8'h00, 16'h0000);
    expect_frame();
    respond(8'($urandom));
    check("final_drop", drop, drop_exp);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
